pl_rv32_fetch_unit: RTL
=======================

# pl_rv32_fetch_unit

Instruction fetch stage for the RV32 pipeline: the producer side of the instruction-decode interface consumed by the decode-stage controller. It holds the PC, issues word requests to instruction memory over a valid/ready request channel, accepts variable-latency responses, buffers up to two fetched instructions, and presents the head instruction with pre-sliced fields to decode under a valid/ready handshake. A redirect from execute (branch or jump) flushes the buffer, discards any in-flight response and restarts fetch at the target.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- BUF_DEPTH, 2, instruction buffer entries; legal values are 1 or 2.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word address, always equal to the PC; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid, single cycle, arrives in order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  execute-stage redirect.
- redirect_target  in  32  new PC.
- id_valid  out  1  head instruction valid.
- id_ready  in  1  decode consumes the head instruction.
- id_instr  out  32  head instruction word.
- id_pc  out  32  PC of the head instruction.
- id_opcode  out  7  id_instr[6:0].
- id_funct3  out  3  id_instr[14:12].
- id_rd  out  5  id_instr[11:7].
- id_rs1  out  5  id_instr[19:15].
- id_rs2  out  5  id_instr[24:20].
- fetch_fault  out  1  sticky misaligned-redirect fault; present only when the configuration macro below is defined, otherwise tied to 0.

## Operation
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, its response is kept.
  - DROP: one request outstanding, its response is discarded.
  - FAULT: exists only under the macro.
- At most one outstanding request.
- Request rule: imem_req_valid = (state==IDLE) && !redirect_valid && (count + 1 <= BUF_DEPTH).
  - count is the current number of buffered entries.
  - count is evaluated before any pop in the same cycle.
- On a request handshake (valid && ready):
  - issued PC is latched as req_pc;
  - PC <= PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0);
  - state goes to WAIT.
- WAIT with imem_rsp_valid:
  - push {req_pc, imem_rsp_data} into the buffer;
  - state goes to IDLE.
  - Room is guaranteed by the request rule, so overflow cannot occur.
- DROP with imem_rsp_valid: discard the response; state goes to IDLE.
- Buffer is a FIFO. id_valid = count != 0. A pop happens when id_valid && id_ready.
- Push and pop in the same cycle are legal; count is unchanged.
- Redirect has highest priority. On redirect_valid:
  - PC <= redirect_target;
  - buffer is flushed (count=0), including an entry being pushed or popped that cycle;
  - IDLE stays IDLE;
  - WAIT goes to DROP, unless imem_rsp_valid is high that cycle, in which case the response is dropped and the state goes to IDLE;
  - DROP stays DROP, unless a response arrives that cycle, in which case the state goes to IDLE.
- Without the macro, redirect_target[1:0] is forced to 0.
- Reset values:
  - PC=RESET_VECTOR, state=IDLE, count=0;
  - imem_req_valid=0 while rst_n is low;
  - id_valid=0, id_instr/id_pc=0, fetch_fault=0.
- Reset asserted mid-transaction discards everything. A response that arrives after reset releases while no request is outstanding is ignored.

## Timing
- First imem_req_valid is in the first cycle after rst_n deasserts, with addr=RESET_VECTOR.
- A response is legal no earlier than the cycle after its request handshake.
- Pushed entry becomes visible on id_* the cycle after the push (registered buffer).
- Next request can issue the cycle after a response. Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- After a redirect in cycle N:
  - a request to the target is possible in N+1 if the state is IDLE;
  - id_valid is 0 in N+1.
- id_* fields are combinational slices of the buffer head and are stable while id_valid && !id_ready.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - a redirect with target[1:0]!=0 sets fetch_fault=1 and enters FAULT (or DROP-then-FAULT if a request is outstanding);
  - in FAULT no requests are issued and the buffer stays empty;
  - fault is cleared only by an aligned redirect or by reset.
- FETCH_MISALIGN_TRAP_EN undefined:
  - target bits [1:0] are silently cleared;
  - fetch_fault is constant 0 and the FAULT state is absent.

## Test plan
- Reset, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, id_ready=1 -> addresses 0,4,8,... in order; id_pc/id_instr match; id_opcode=id_instr[6:0].
- id_ready=0 with BUF_DEPTH=2 -> exactly two requests issued, then imem_req_valid stays 0; release id_ready -> fetch resumes at PC 8 with no loss or duplication.
- Redirect to 0x100 while a request for 0x8 is outstanding with a 3-cycle response -> 0x8 response is dropped, never seen on id_*, next request is 0x100.
- Redirect in the same cycle as a response, with one entry in the buffer being popped -> buffer empty next cycle, state IDLE, request to the target the following cycle.
- RESET_VECTOR=32'hFFFF_FFF8 -> requests to FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> fetch_fault=1, no requests; then redirect to 0x200 -> fault clears, request to 0x200. Without the macro: redirect to 0x102 -> request to 0x100.

Source files
------------

// File: rtl/pl_rv32_fetch_unit.sv
// ============================================================================
// pl_rv32_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage of the RV32 pipeline.
//
// The unit holds the PC and requests one instruction word at a time from
// instruction memory. Responses are pushed into a small in-order buffer. The
// head of the buffer is presented to decode with its fields already sliced
// out. A redirect from execute flushes the buffer, discards any response
// still in flight and restarts fetch at the redirect target.
//
// Parameters
//   RESET_VECTOR     PC after reset (word aligned)
//   BUF_DEPTH        instruction buffer entries, 1 or 2
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   imem_req_valid   request valid (forced low while rst_n is low)
//   imem_req_ready   memory accepts the request
//   imem_addr        word address of the request, always equal to the PC
//   imem_rsp_valid   single-cycle, in-order response strobe
//   imem_rsp_data    instruction word of the response
//   redirect_valid   execute-stage redirect (branch / jump)
//   redirect_target  new PC
//   id_valid         head instruction valid
//   id_ready         decode consumes the head instruction
//   id_instr         head instruction word
//   id_pc            PC of the head instruction
//   id_opcode/funct3/rd/rs1/rs2   fields sliced from id_instr
//   fetch_fault      sticky misaligned-redirect fault
//
// Configuration macro
//   FETCH_MISALIGN_TRAP_EN
//     defined   : a redirect to a target with bits [1:0] != 0 sets
//                 fetch_fault and parks fetch in FAULT until an aligned
//                 redirect or reset
//     undefined : target bits [1:0] are silently cleared; fetch_fault is 0
// ============================================================================
`timescale 1ns/1ps

module pl_rv32_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [6:0]  id_opcode,
   output logic [2:0]  id_funct3,
   output logic [4:0]  id_rd,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic        fetch_fault
);

   localparam logic [1:0] LP_DEPTH = BUF_DEPTH[1:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
      ,ST_FAULT = 2'd3
`endif
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic [1:0]  r_count;
   logic [31:0] r_buf_instr [2];
   logic [31:0] r_buf_pc    [2];

   logic [31:0] w_tgt_aligned;
   logic        w_req_valid;
   logic        w_req_fire;
   logic        w_id_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_wr_hi;
   state_t      w_after_rsp;

   assign w_tgt_aligned = {redirect_target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_fault;
   logic w_tgt_mis;
   logic w_fault_nxt;

   assign w_tgt_mis   = (redirect_target[1:0] != 2'b00);
   // A redirect rewrites the fault flag; otherwise it is sticky.
   assign w_fault_nxt = redirect_valid ? w_tgt_mis : r_fault;
   // Where the FSM lands once nothing is outstanding any more.
   assign w_after_rsp = w_fault_nxt ? ST_FAULT : ST_IDLE;
   assign fetch_fault = r_fault;
`else
   logic [1:0] w_unused_tgt_lsb;

   assign w_unused_tgt_lsb = redirect_target[1:0];
   assign w_after_rsp      = ST_IDLE;
   assign fetch_fault      = 1'b0;
`endif

   // A request may only go out when nothing is outstanding and the
   // response is guaranteed a free buffer slot (count taken before any pop).
   assign w_req_valid = rst_n && (r_state == ST_IDLE) && !redirect_valid &&
                        (r_count < LP_DEPTH);
   assign w_req_fire  = w_req_valid && imem_req_ready;
   assign w_id_valid  = (r_count != 2'd0);
   assign w_pop       = w_id_valid && id_ready;
   assign w_push      = (r_state == ST_WAIT) && imem_rsp_valid;
   // Push slot is the first free entry after this cycle's pop shifts the FIFO.
   assign w_wr_hi     = ((r_count - {1'b0, w_pop}) == 2'd1);

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_pc;

   assign id_valid  = w_id_valid;
   assign id_instr  = r_buf_instr[0];
   assign id_pc     = r_buf_pc[0];
   assign id_opcode = r_buf_instr[0][6:0];
   assign id_funct3 = r_buf_instr[0][14:12];
   assign id_rd     = r_buf_instr[0][11:7];
   assign id_rs1    = r_buf_instr[0][19:15];
   assign id_rs2    = r_buf_instr[0][24:20];

   // ------------------------------------------------------------------------
   // Request FSM and PC
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pc     <= {RESET_VECTOR[31:2], 2'b00};
         r_req_pc <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_fault  <= 1'b0;
`endif
      end else if (redirect_valid) begin
         r_pc <= w_tgt_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_fault <= w_tgt_mis;
`endif
         // An outstanding request keeps us in DROP until its response shows
         // up; a response in this very cycle is simply discarded.
         if (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !imem_rsp_valid)
            r_state <= ST_DROP;
         else
            r_state <= w_after_rsp;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_fire) begin
                  r_req_pc <= r_pc;
                  r_pc     <= r_pc + 32'd4;
                  r_state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid)
                  r_state <= ST_IDLE;
            end
            ST_DROP: begin
               if (imem_rsp_valid)
                  r_state <= w_after_rsp;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: r_state <= ST_FAULT;
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Instruction buffer: entry 0 is always the head, a pop shifts entry 1 down
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count        <= 2'd0;
         r_buf_instr[0] <= 32'h0;
         r_buf_instr[1] <= 32'h0;
         r_buf_pc[0]    <= 32'h0;
         r_buf_pc[1]    <= 32'h0;
      end else if (redirect_valid) begin
         r_count <= 2'd0;
      end else begin
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop) begin
            r_buf_instr[0] <= r_buf_instr[1];
            r_buf_pc[0]    <= r_buf_pc[1];
         end
         // Placed after the shift so a push into slot 0 wins over it.
         if (w_push) begin
            if (w_wr_hi) begin
               r_buf_instr[1] <= imem_rsp_data;
               r_buf_pc[1]    <= r_req_pc;
            end else begin
               r_buf_instr[0] <= imem_rsp_data;
               r_buf_pc[0]    <= r_req_pc;
            end
         end
      end
   end

endmodule
